// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// Module      : render_pkg
// Description : Shared encodings for the block renderer: game status codes,
//               renderer FSM states and default colours.
// Revision    : 1.0 - initial release
// ============================================================================
package render_pkg;

    // Game status codes produced by the game logic; 2'b11 behaves as START
    localparam logic [1:0] ST_START     = 2'b00;
    localparam logic [1:0] ST_PLAYING   = 2'b01;
    localparam logic [1:0] ST_GAME_OVER = 2'b10;

    // Renderer sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        CLEAR = 2'd3
    } render_state_t;

    // Default colours
    localparam logic [2:0] DEF_BG_COLOUR    = 3'b000;
    localparam logic [2:0] DEF_BLOCK_COLOUR = 3'b111;

endpackage
`default_nettype wire

// File: rtl/rect_sweep.sv
`default_nettype none
// ============================================================================
// Module      : rect_sweep
// Description : Raster walk over a rectangle, one pixel per clock, column
//               fastest. Pixel coordinates and the on-screen flag are
//               registered; the first pixel appears the cycle after start.
// Revision    : 1.0 - initial release
// ============================================================================
module rect_sweep #(
    parameter int CLIP_W = 160,
    parameter int CLIP_H = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] px,
    output logic [6:0] py,
    output logic       visible,
    output logic       last
);

    localparam logic [8:0] C_CLIP_W = 9'(CLIP_W);
    localparam logic [7:0] C_CLIP_H = 8'(CLIP_H);

    logic [7:0] r_ox;
    logic [6:0] r_oy;
    logic [7:0] r_w;
    logic [6:0] r_h;
    logic [7:0] r_c;
    logic [6:0] r_r;
    logic       r_active;
    logic [7:0] r_px;
    logic [6:0] r_py;
    logic       r_vis;
    logic       r_last;

    logic       w_col_wrap;
    logic [7:0] w_c_nxt;
    logic [6:0] w_r_nxt;
    logic [7:0] w_base_x;
    logic [6:0] w_base_y;
    logic [7:0] w_dim_w;
    logic [6:0] w_dim_h;
    logic [7:0] w_off_c;
    logic [6:0] w_off_r;
    logic [8:0] w_sum_x;
    logic [7:0] w_sum_y;
    logic       w_in;
    logic       w_last_nxt;

    // Next counter position and the pixel it maps to; a start restarts at the
    // new origin so the sums are taken at full width to catch off-screen pixels
    always_comb begin
        w_col_wrap = (r_c == (r_w - 8'd1));
        w_c_nxt    = w_col_wrap ? 8'd0 : (r_c + 8'd1);
        w_r_nxt    = w_col_wrap ? (r_r + 7'd1) : r_r;
        w_base_x   = start ? org_x  : r_ox;
        w_base_y   = start ? org_y  : r_oy;
        w_dim_w    = start ? width  : r_w;
        w_dim_h    = start ? height : r_h;
        w_off_c    = start ? 8'd0   : w_c_nxt;
        w_off_r    = start ? 7'd0   : w_r_nxt;
        w_sum_x    = {1'b0, w_base_x} + {1'b0, w_off_c};
        w_sum_y    = {1'b0, w_base_y} + {1'b0, w_off_r};
        w_in       = (w_sum_x < C_CLIP_W) && (w_sum_y < C_CLIP_H);
        w_last_nxt = (w_off_c == (w_dim_w - 8'd1)) && (w_off_r == (w_dim_h - 7'd1));
    end

    // Sweep state: latch geometry on start, advance one pixel per cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ox     <= 8'd0;
            r_oy     <= 7'd0;
            r_w      <= 8'd0;
            r_h      <= 7'd0;
            r_c      <= 8'd0;
            r_r      <= 7'd0;
            r_active <= 1'b0;
            r_px     <= 8'd0;
            r_py     <= 7'd0;
            r_vis    <= 1'b0;
            r_last   <= 1'b0;
        end else if (start) begin
            r_ox     <= org_x;
            r_oy     <= org_y;
            r_w      <= width;
            r_h      <= height;
            r_c      <= 8'd0;
            r_r      <= 7'd0;
            r_active <= 1'b1;
            r_px     <= w_sum_x[7:0];
            r_py     <= w_sum_y[6:0];
            r_vis    <= w_in;
            r_last   <= w_last_nxt;
        end else if (r_active) begin
            if (r_last) begin
                r_active <= 1'b0;
                r_vis    <= 1'b0;
                r_last   <= 1'b0;
            end else begin
                r_c    <= w_c_nxt;
                r_r    <= w_r_nxt;
                r_px   <= w_sum_x[7:0];
                r_py   <= w_sum_y[6:0];
                r_vis  <= w_in;
                r_last <= w_last_nxt;
            end
        end
    end

    assign px      = r_px;
    assign py      = r_py;
    assign visible = r_vis;
    assign last    = r_last;

endmodule
`default_nettype wire

// File: rtl/block_render_fsm.sv
`default_nettype none
// ============================================================================
// Module      : block_render_fsm
// Description : Redraws the moving block on each frame tick (erase old
//               footprint, draw new one) and clears the screen once on entry
//               to game-over. Emits at most one pixel write per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module block_render_fsm
    import render_pkg::*;
#(
    parameter int         BLOCK_W      = 20,
    parameter int         BLOCK_H      = 4,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] BG_COLOUR    = DEF_BG_COLOUR,
    parameter logic [2:0] BLOCK_COLOUR = DEF_BLOCK_COLOUR
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sync,
    input  logic [7:0] x,
    input  logic [7:0] prev_x,
    input  logic [6:0] y,
    input  logic [1:0] game_status,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam logic [7:0] C_BLOCK_W  = 8'(BLOCK_W);
    localparam logic [6:0] C_BLOCK_H  = 7'(BLOCK_H);
    localparam logic [7:0] C_SCREEN_W = 8'(SCREEN_W);
    localparam logic [6:0] C_SCREEN_H = 7'(SCREEN_H);

    render_state_t r_state;
    render_state_t w_state_next;
    logic [7:0]    r_x_l;
    logic [6:0]    r_y_l;
    logic          r_cleared;
    logic [2:0]    r_colour;
    logic          r_busy;

    logic          w_latch;
    logic          w_cleared_next;
    logic [2:0]    w_colour_next;
    logic          w_sw_start;
    logic [7:0]    w_sw_org_x;
    logic [6:0]    w_sw_org_y;
    logic [7:0]    w_sw_w;
    logic [6:0]    w_sw_h;
    logic [7:0]    w_sw_px;
    logic [6:0]    w_sw_py;
    logic          w_sw_vis;
    logic          w_sw_last;

    rect_sweep #(
        .CLIP_W (SCREEN_W),
        .CLIP_H (SCREEN_H)
    ) u_sweep (
        .clk     (clk),
        .resetn  (resetn),
        .start   (w_sw_start),
        .org_x   (w_sw_org_x),
        .org_y   (w_sw_org_y),
        .width   (w_sw_w),
        .height  (w_sw_h),
        .px      (w_sw_px),
        .py      (w_sw_py),
        .visible (w_sw_vis),
        .last    (w_sw_last)
    );

    // Next-state logic: pick the sweep to launch and its colour; a new sweep
    // is launched on the last pixel of ERASE so DRAW follows with no gap
    always_comb begin
        w_state_next   = r_state;
        w_latch        = 1'b0;
        w_cleared_next = r_cleared;
        w_colour_next  = r_colour;
        w_sw_start     = 1'b0;
        w_sw_org_x     = prev_x;
        w_sw_org_y     = y;
        w_sw_w         = C_BLOCK_W;
        w_sw_h         = C_BLOCK_H;
        case (r_state)
            IDLE: begin
                if (game_status != ST_GAME_OVER) begin
                    w_cleared_next = 1'b0;
                end
                if (sync && (game_status == ST_PLAYING)) begin
                    w_latch       = 1'b1;
                    w_sw_start    = 1'b1;
                    w_colour_next = BG_COLOUR;
                    w_state_next  = ERASE;
                end else if (sync && (game_status == ST_GAME_OVER) && !r_cleared) begin
                    w_sw_start    = 1'b1;
                    w_sw_org_x    = 8'd0;
                    w_sw_org_y    = 7'd0;
                    w_sw_w        = C_SCREEN_W;
                    w_sw_h        = C_SCREEN_H;
                    w_colour_next = BG_COLOUR;
                    w_state_next  = CLEAR;
                end
            end
            ERASE: begin
                if (w_sw_last) begin
                    w_sw_start    = 1'b1;
                    w_sw_org_x    = r_x_l;
                    w_sw_org_y    = r_y_l;
                    w_colour_next = BLOCK_COLOUR;
                    w_state_next  = DRAW;
                end
            end
            DRAW: begin
                if (w_sw_last) begin
                    w_state_next = IDLE;
                end
            end
            CLEAR: begin
                if (w_sw_last) begin
                    w_cleared_next = 1'b1;
                    w_state_next   = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register plus latched block position, one-shot clear flag and
    // registered colour/busy outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_x_l     <= 8'd0;
            r_y_l     <= 7'd0;
            r_cleared <= 1'b0;
            r_colour  <= 3'b000;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cleared <= w_cleared_next;
            r_colour  <= w_colour_next;
            r_busy    <= (w_state_next != IDLE);
            if (w_latch) begin
                r_x_l <= x;
                r_y_l <= y;
            end
        end
    end

    assign vga_x  = w_sw_px;
    assign vga_y  = w_sw_py;
    assign plot   = w_sw_vis;
    assign colour = r_colour;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_block_render_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_render_fsm
// Description : Self-checking bench for block_render_fsm. Expected pixel
//               streams come from a nested-loop model of the erase/draw and
//               clear rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_render_fsm;

    localparam int BW = 20;
    localparam int BH = 4;
    localparam int SW = 160;
    localparam int SH = 120;
    localparam int BG = 0;
    localparam int FG = 7;
    localparam logic [1:0] S_START = 2'b00;
    localparam logic [1:0] S_PLAY  = 2'b01;
    localparam logic [1:0] S_OVER  = 2'b10;
    localparam logic [1:0] S_RSVD  = 2'b11;

    logic       clk = 1'b0;
    logic       resetn;
    logic       sync;
    logic [7:0] x;
    logic [7:0] prev_x;
    logic [6:0] y;
    logic [1:0] game_status;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // {busy, plot, colour, vga_y, vga_x}
    logic [19:0] exp_q[$];
    int          exp_plots;

    block_render_fsm dut (
        .clk         (clk),
        .resetn      (resetn),
        .sync        (sync),
        .x           (x),
        .prev_x      (prev_x),
        .y           (y),
        .game_status (game_status),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] obs_vec();
        return {busy, plot, colour, vga_y, vga_x};
    endfunction

    // Expected erase-then-draw pixel stream for one frame
    task automatic build_model(input int px, input int nx, input int ny);
        exp_q.delete();
        exp_plots = 0;
        for (int pass = 0; pass < 2; pass++) begin
            int ox  = (pass == 0) ? px : nx;
            int col = (pass == 0) ? BG : FG;
            for (int r = 0; r < BH; r++) begin
                for (int c = 0; c < BW; c++) begin
                    int xs  = ox + c;
                    int ys  = ny + r;
                    bit vis = (xs < SW) && (ys < SH);
                    if (vis) exp_plots++;
                    exp_q.push_back({1'b1, vis, 3'(col), 7'(ys), 8'(xs)});
                end
            end
        end
    endtask

    // One PLAYING frame; optional dropped resync at cycle 50 and optional
    // reset at a given pixel index (-1 = none)
    task automatic run_frame(input string name, input int px, input int nx, input int ny,
                             input bit resync, input int reset_at);
        int plots = 0;
        int busy_cnt = 0;
        build_model(px, nx, ny);
        prev_x = 8'(px); x = 8'(nx); y = 7'(ny);
        game_status = S_PLAY;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        // inputs wander mid-sweep; only latched copies may be used
        x = 8'($urandom); prev_x = 8'($urandom); y = 7'($urandom);
        for (int k = 0; k < 2 * BW * BH + 3; k++) begin
            if (k < 2 * BW * BH)
                chk($sformatf("%s_px%0d", name, k), 32'(obs_vec()), 32'(exp_q[k]));
            else
                chk($sformatf("%s_idle%0d", name, k), 32'({busy, plot}), 32'(0));
            if (plot) plots++;
            if (busy) busy_cnt++;
            if (k == reset_at) begin
                resetn = 1'b0;
                tick();
                chk($sformatf("%s_reset", name), 32'(obs_vec()), 32'(0));
                resetn = 1'b1;
                tick();
                chk($sformatf("%s_after_reset", name), 32'({busy, plot}), 32'(0));
                return;
            end
            sync = resync && (k == 50);
            tick();
        end
        sync = 1'b0;
        chk($sformatf("%s_busy_cycles", name), 32'(busy_cnt), 32'(2 * BW * BH));
        chk($sformatf("%s_plot_count", name), 32'(plots), 32'(exp_plots));
    endtask

    // Count plots and busy cycles over a window with periodic syncs
    task automatic quiet_window(input string name, input logic [1:0] st);
        int act = 0;
        game_status = st;
        for (int k = 0; k < 60; k++) begin
            sync = (k % 20 == 0);
            tick();
            if (plot || busy) act++;
        end
        sync = 1'b0;
        chk(name, 32'(act), 32'(0));
    endtask

    initial begin
        int n_clr, clr_err, clr_busy;
        resetn = 1'b0; sync = 1'b0; x = 8'd0; prev_x = 8'd0; y = 7'd0;
        game_status = S_START;
        repeat (3) tick();
        chk("reset_state", 32'(obs_vec()), 32'(0));
        resetn = 1'b1;
        tick();
        chk("idle_after_reset", 32'(obs_vec()), 32'(0));

        run_frame("basic", 40, 44, 100, 1'b1, -1);
        run_frame("right_edge", 150, 150, 10, 1'b0, -1);
        run_frame("bottom_overrun", 250, 3, 118, 1'b0, -1);
        run_frame("mid_draw_reset", 20, 30, 50, 1'b0, 110);
        run_frame("fresh_after_reset", 20, 30, 50, 1'b0, -1);

        // Game-over clear: exactly one raster sweep, syncs during it dropped
        game_status = S_OVER;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        n_clr = 0; clr_err = 0; clr_busy = 0;
        for (int k = 0; k < SW * SH + 10; k++) begin
            if (plot) begin
                if (vga_x != 8'(n_clr % SW) || vga_y != 7'(n_clr / SW) || colour != 3'(BG))
                    clr_err++;
                n_clr++;
            end
            if (busy) clr_busy++;
            sync = (k % 500 == 499);
            tick();
        end
        sync = 1'b0;
        chk("clear_plots", 32'(n_clr), 32'(SW * SH));
        chk("clear_busy", 32'(clr_busy), 32'(SW * SH));
        chk("clear_order", 32'(clr_err), 32'(0));

        quiet_window("gameover_oneshot", S_OVER);
        quiet_window("start_idle", S_START);
        quiet_window("reserved_idle", S_RSVD);

        // Having left game-over, a fresh game-over tick clears again
        game_status = S_OVER;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("reclear_first", 32'({busy, plot, colour, vga_y, vga_x}), 32'({1'b1, 1'b1, 3'(BG), 7'd0, 8'd0}));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("reclear_abort", 32'({busy, plot}), 32'(0));
        tick();

        for (int f = 0; f < 5; f++) begin
            run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                      1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_render_fsm.md
Name: block_render_fsm

Overview:
- Downstream consumer of the game logic top-level outputs (x, prev_x, y, game_status).
- On each frame tick, it redraws the moving block through the VGA adapter's pixel-write port. It first erases the block's previous footprint, then draws the new one.
- On entry to game-over it clears the whole screen.
- It emits one pixel write per clock.

Parameters:
- BLOCK_W, 20, block width in pixels
- BLOCK_H, 4, block height in pixels
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are not plotted
- SCREEN_H, 120, visible height; used by the clear sweep
- BG_COLOUR, 3'b000, erase and clear colour
- BLOCK_COLOUR, 3'b111, block colour

Ports:
- clk  in  1  50MHz system clock
- resetn  in  1  synchronous, active-low reset
- sync  in  1  one-cycle frame tick from the delay counter
- x  in  8  current block x (left edge)
- prev_x  in  8  previous block x (left edge)
- y  in  7  block y (top edge)
- game_status  in  2  game status from game logic
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  pixel write enable; one pixel per cycle when high
- busy  out  1  high while in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. resetn is synchronous and active-low. All outputs are registered.
- Reset values: state=IDLE; vga_x=0, vga_y=0, colour=0, plot=0, busy=0; pixel counters=0; cleared flag=0.
- Reset mid-operation: on the clock edge where resetn=0, the block returns to IDLE and plot=0 the next cycle. No partial pixels are emitted after reset.
- game_status encoding (package): 2'b00 START, 2'b01 PLAYING, 2'b10 GAME_OVER, 2'b11 reserved (treated as START).
- IDLE:
  - sync=1 and status=PLAYING: latch x, prev_x, y; go to ERASE.
  - sync=1 and status=GAME_OVER and cleared=0: go to CLEAR.
  - Any other case: stay in IDLE.
- cleared flag:
  - Set when CLEAR completes.
  - Cleared whenever status is sampled != GAME_OVER in IDLE.
  - This makes the clear a one-shot per game-over.
- ERASE:
  - Col counter c (0..BLOCK_W-1) is the fast counter; row counter r (0..BLOCK_H-1) is the slow counter.
  - Each cycle: vga_x = prev_x+c, vga_y = y_latched+r, colour = BG_COLOUR.
  - plot=1 unless prev_x+c >= SCREEN_W (9-bit sum compared; no 8-bit wrap).
  - After the pixel (BLOCK_W-1, BLOCK_H-1): counters reset, go to DRAW.
- DRAW: identical sweep at x_latched with BLOCK_COLOUR. After the last pixel, go to IDLE.
- CLEAR:
  - Sweep vga_x 0..SCREEN_W-1 (fast) and vga_y 0..SCREEN_H-1 (slow).
  - colour = BG_COLOUR, plot=1 throughout.
  - After the last pixel: set cleared, go to IDLE.
- Latency: the first plot pixel appears on the cycle after the IDLE edge that sampled sync.
- Sweep lengths: ERASE+DRAW = 2*BLOCK_W*BLOCK_H cycles (160 at defaults). CLEAR = SCREEN_W*SCREEN_H cycles (19200).
- Back-to-back tick: sync arriving while busy=1 is dropped, not queued.
- Inputs changing mid-sweep do not affect the current sweep; only the latched copies are used.
- Same position: prev_x == x still performs erase then draw. The net result is the block drawn at x.
- Overrun: y_latched+r beyond SCREEN_H-1 is not plotted (8-bit sum compared).
- plot is 0 in IDLE, so it is 0 on every cycle outside a sweep.

Decomposition:
- Package render_pkg holds:
  - game_status localparams: ST_START, ST_PLAYING, ST_GAME_OVER
  - FSM state encoding: IDLE, ERASE, DRAW, CLEAR
  - default colour constants
- One sub-module is natural: rect_sweep.
  - Inputs: origin x/y, width, height, start.
  - Outputs: pixel x/y, valid, last.
  - Used for ERASE, DRAW and CLEAR (CLEAR = origin 0,0, SCREEN_W x SCREEN_H).
- The FSM in block_render_fsm sequences rect_sweep and muxes colour.

Test Plan:
- Reset during DRAW (resetn=0 at pixel 30) -> next cycle plot=0, busy=0; the following sync with PLAYING starts a fresh ERASE at pixel 0.
- PLAYING, prev_x=40, x=44, y=100, sync pulse -> cycle+1 plot=1 at (40,100), BG. 80 erase pixels ending at (59,103), then 80 draw pixels (44..63, 100..103) BLOCK_COLOUR. busy high for exactly 160 cycles.
- sync pulsed again 50 cycles into a sweep -> ignored; exactly 160 plots total, no restart.
- x=150, prev_x=150 -> pixels with x 160..169 have plot=0. Plotted count = 10 per row, i.e. 40 erase + 40 draw.
- GAME_OVER with a sync each frame -> one CLEAR of 19200 plots covering (0,0)..(159,119). Subsequent syncs do nothing until status leaves GAME_OVER and returns.
- Status START or 2'b11 with sync -> no plots, busy stays 0.
